conv_out_writer: RTL and testbench

- Downstream writeback stage of the conv accelerator. Consumes the raw 32-bit accumulator stream from the conv datapath and adds the per-channel bias fetched from Bias SRAM.
- Requantizes each result to int8 (round, shift, saturate, optional ReLU) and writes it into the Output SRAM word space: 16-bit words, int8 result sign-extended, linear address across the 6×32768-word blocks.
- Asserts `finish` when the layer's output is complete.

---
 rtl/conv_out_writer.sv | 194 +++++++++++++++++++
 tb/tb_conv_out_writer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_writer.sv
// conv_out_writer: writeback stage of the conv accelerator. Adds the
// per-channel bias (read from Bias SRAM) to each 32-bit accumulator,
// requantizes to int8 (round half up, arithmetic shift, saturate) and
// writes the sign-extended result to the Output SRAM word space.
// Optional feature: define OUT_WRITER_RELU_EN to clamp negatives to 0.
// Ports:
//   clk, rst          clock, async active-high reset
//   start             launch pulse (IDLE only); samples num_ch, ch_len,
//                     shift, base_addr
//   in_valid/in_ready accumulator handshake, in_acc channel-major data
//   bias_cs/addr      Bias SRAM read; bias_rdata valid one cycle later
//   out_cs/we/addr    Output SRAM write port, out_wdata = sext(int8)
//   finish            one-cycle pulse when the layer is complete
module conv_out_writer #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 18,
  parameter int BADDR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_ch,
  input  logic [CNT_W-1:0]   ch_len,
  input  logic [4:0]         shift,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ACC_W-1:0]   in_acc,
  output logic               bias_cs,
  output logic [BADDR_W-1:0] bias_addr,
  input  logic [ACC_W-1:0]   bias_rdata,
  output logic               out_cs,
  output logic               out_we,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [15:0]        out_wdata,
  output logic               finish
);

  typedef enum logic [2:0] {
    IDLE, BIAS_REQ, BIAS_WAIT, STREAM, DRAIN, DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  num_ch_r;
  logic [CNT_W-1:0]  ch_len_r;
  logic [4:0]        shift_r;
  logic [CNT_W-1:0]  ch_idx;
  logic [CNT_W-1:0]  pix_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ACC_W-1:0]  bias_reg;

  logic              s1_valid;
  logic [ACC_W:0]    s1_sum;
  logic              s2_valid;
  logic [7:0]        s2_res;

  logic hs;
  logic last_pix;
  logic last_ch;

  assign hs       = in_valid & in_ready;
  assign last_pix = (pix_cnt == ch_len_r - CNT_W'(1));
  assign last_ch  = (ch_idx == num_ch_r - CNT_W'(1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_ch == '0 || ch_len == '0) state_nx = DONE;
          else                              state_nx = BIAS_REQ;
        end
      end
      BIAS_REQ:  state_nx = BIAS_WAIT;
      BIAS_WAIT: state_nx = STREAM;
      STREAM: begin
        if (hs && last_pix) begin
          if (last_ch) state_nx = DRAIN;
          else         state_nx = BIAS_REQ;
        end
      end
      // S2 retires its last write on this edge once S1 is empty,
      // so finish lands in the cycle right after that write.
      DRAIN: begin
        if (!s1_valid) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded outputs and the write port
  always_comb begin
    in_ready  = (state == STREAM);
    bias_cs   = (state == BIAS_REQ);
    bias_addr = '0;
    if (state == BIAS_REQ) bias_addr = ch_idx[BADDR_W-1:0];
    finish    = (state == DONE);
    out_cs    = s2_valid;
    out_we    = s2_valid;
    out_addr  = '0;
    out_wdata = '0;
    if (s2_valid) begin
      out_addr  = wr_addr;
      out_wdata = {{8{s2_res[7]}}, s2_res};
    end
  end

  // requantize: round half up, arithmetic shift, saturate
  logic [ACC_W+1:0]        rnd;
  logic signed [ACC_W+1:0] biased;
  logic signed [ACC_W+1:0] shifted;
  logic                    pos_ovf;
  logic                    neg_ovf;
  logic [7:0]              sat;

  always_comb begin
    rnd = '0;
    if (shift_r != '0)
      rnd = {{(ACC_W+1){1'b0}}, 1'b1} << (shift_r - 5'd1);
    biased  = {s1_sum[ACC_W], s1_sum} + rnd;
    shifted = biased >>> shift_r;
    pos_ovf = !shifted[ACC_W+1] && (|shifted[ACC_W:7]);
    neg_ovf = shifted[ACC_W+1] && !(&shifted[ACC_W:7]);
`ifdef OUT_WRITER_RELU_EN
    if (shifted[ACC_W+1]) sat = 8'h00;
    else if (pos_ovf)     sat = 8'h7F;
    else                  sat = shifted[7:0];
`else
    if (pos_ovf)      sat = 8'h7F;
    else if (neg_ovf) sat = 8'h80;
    else              sat = shifted[7:0];
`endif
  end

  // counters, bias capture and the two pipeline stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_ch_r <= '0;
      ch_len_r <= '0;
      shift_r  <= '0;
      ch_idx   <= '0;
      pix_cnt  <= '0;
      wr_addr  <= '0;
      bias_reg <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
    end else begin
      if (state == IDLE && start) begin
        num_ch_r <= num_ch;
        ch_len_r <= ch_len;
        shift_r  <= shift;
        ch_idx   <= '0;
        pix_cnt  <= '0;
        wr_addr  <= base_addr;
      end else if (s2_valid) begin
        wr_addr  <= wr_addr + ADDR_W'(1);
      end

      if (state == BIAS_WAIT) bias_reg <= bias_rdata;

      if (hs) begin
        if (last_pix) begin
          pix_cnt <= '0;
          ch_idx  <= ch_idx + CNT_W'(1);
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end

      // bias is bound at accept time; bias_reg may reload behind it
      s1_valid <= hs;
      if (hs)
        s1_sum <= {in_acc[ACC_W-1], in_acc}
                + {bias_reg[ACC_W-1], bias_reg};

      s2_valid <= s1_valid;
      if (s1_valid) s2_res <= sat;
    end
  end

endmodule

// File: tb/tb_conv_out_writer.sv
// tb_conv_out_writer: randomized self-checking bench for conv_out_writer.
// Compares every write, bias read and finish pulse against a model.
module tb_conv_out_writer;
  localparam int ACC_W   = 32;
  localparam int ADDR_W  = 18;
  localparam int BADDR_W = 9;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [CNT_W-1:0]   num_ch = '0;
  logic [CNT_W-1:0]   ch_len = '0;
  logic [4:0]         shift = '0;
  logic [ADDR_W-1:0]  base_addr = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [ACC_W-1:0]   in_acc = '0;
  logic               bias_cs;
  logic [BADDR_W-1:0] bias_addr;
  logic [ACC_W-1:0]   bias_rdata = '0;
  logic               out_cs;
  logic               out_we;
  logic [ADDR_W-1:0]  out_addr;
  logic [15:0]        out_wdata;
  logic               finish;

  conv_out_writer #(
    .ACC_W(ACC_W), .ADDR_W(ADDR_W),
    .BADDR_W(BADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_ch(num_ch), .ch_len(ch_len),
    .shift(shift), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_acc(in_acc), .bias_cs(bias_cs),
    .bias_addr(bias_addr), .bias_rdata(bias_rdata),
    .out_cs(out_cs), .out_we(out_we),
    .out_addr(out_addr), .out_wdata(out_wdata),
    .finish(finish)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [31:0] acc_q[$];
  logic [31:0] bias_mem[0:511];

  int          wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          fin_q[$];
  int          ba_q[$];
  int          hs_q[$];
  int          idle_bad = 0;
  int          bubble = 0;
  int          start_cyc = 0;

  // Bias SRAM: one-cycle read latency
  always @(posedge clk)
    if (bias_cs) bias_rdata <= bias_mem[bias_addr];

  // Output SRAM / status monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (out_cs) begin
        wa_q.push_back(int'(out_addr));
        wd_q.push_back(out_wdata);
        wc_q.push_back(cyc);
      end else if (out_addr != 0 || out_wdata != 0) begin
        idle_bad++;
      end
      if (out_we !== out_cs) idle_bad++;
      if (bias_cs) ba_q.push_back(int'(bias_addr));
      if (finish) fin_q.push_back(cyc);
    end
  end

  function automatic logic [15:0] model_word(
    input logic [31:0] acc,
    input logic [31:0] bias,
    input int sh
  );
    longint v;
    v = longint'($signed(acc)) + longint'($signed(bias));
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
`ifdef OUT_WRITER_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 16'(v);
  endfunction

  task automatic clear_caps();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    fin_q.delete(); ba_q.delete(); hs_q.delete();
    idle_bad = 0;
    bubble = 0;
  endtask

  task automatic fill_random(input int n, input int nch,
                             input int amp);
    acc_q.delete();
    for (int i = 0; i < n; i++) begin
      if (amp == 0) acc_q.push_back($urandom);
      else acc_q.push_back(32'(int'($urandom_range(0, 2*amp)) - amp));
    end
    for (int c = 0; c < nch; c++) begin
      if (amp == 0) bias_mem[c] = $urandom;
      else bias_mem[c] = 32'(int'($urandom_range(0, 2*amp)) - amp);
    end
  endtask

  task automatic start_layer(input int nch, input int len,
                             input int sh, input int base);
    @(negedge clk);
    clear_caps();
    num_ch = CNT_W'(nch);
    ch_len = CNT_W'(len);
    shift = 5'(sh);
    base_addr = ADDR_W'(base);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // inputs change at negedge; a handshake happens at the next posedge
  task automatic drive(input int upto, input int gap_pct,
                       input int busy_at);
    int idx = 0;
    int guard = 0;
    bit busy_done = 0;
    while (idx < upto && guard < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_acc = acc_q[idx];
      if (idx == busy_at && !busy_done) begin
        busy_done = 1;
        start = 1'b1;
        num_ch = '0;
        ch_len = '0;
        base_addr = '0;
      end
      if (idx > 0 && !in_ready) bubble++;
      if (in_valid && in_ready) begin
        hs_q.push_back(cyc);
        idx++;
      end
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    in_valid = 1'b0;
    in_acc = '0;
    checks++;
    if (idx != upto) begin
      failures++;
      $display("FAIL drive_timeout accepted=%0d required=%0d",
               idx, upto);
    end
  endtask

  task automatic check_layer(input int nch, input int len,
                             input int sh, input int base);
    int total = nch * len;
    int w = 0;
    int n;
    logic [15:0] ed;
    int ea;
    while (fin_q.size() == 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (fin_q.size() != 1) begin
      failures++;
      $display("FAIL finish_count got=%0d exp=1", fin_q.size());
    end
    checks++;
    if (wa_q.size() != total) begin
      failures++;
      $display("FAIL write_count got=%0d exp=%0d",
               wa_q.size(), total);
    end
    n = (wa_q.size() < total) ? wa_q.size() : total;
    for (int i = 0; i < n; i++) begin
      ea = (base + i) % (1 << ADDR_W);
      ed = model_word(acc_q[i], bias_mem[i / len], sh);
      checks++;
      if (wa_q[i] != ea) begin
        failures++;
        $display("FAIL wr_addr[%0d] got=%h exp=%h", i, wa_q[i], ea);
      end
      checks++;
      if (wd_q[i] !== ed) begin
        failures++;
        $display("FAIL wr_data[%0d] got=%h exp=%h", i, wd_q[i], ed);
      end
      if (i < hs_q.size()) begin
        checks++;
        if (wc_q[i] != hs_q[i] + 2) begin
          failures++;
          $display("FAIL latency[%0d] got=%0d exp=2",
                   i, wc_q[i] - hs_q[i]);
        end
      end
    end
    if (fin_q.size() > 0) begin
      checks++;
      if (total == 0) begin
        if (fin_q[0] != start_cyc + 1) begin
          failures++;
          $display("FAIL finish_delay got=%0d exp=1",
                   fin_q[0] - start_cyc);
        end
      end else if (wc_q.size() > 0) begin
        if (fin_q[0] != wc_q[$] + 1) begin
          failures++;
          $display("FAIL finish_after_write got=%0d exp=1",
                   fin_q[0] - wc_q[$]);
        end
      end else begin
        failures++;
        $display("FAIL finish_without_writes got=0 exp=%0d", total);
      end
    end
    checks++;
    if (ba_q.size() != ((total > 0) ? nch : 0)) begin
      failures++;
      $display("FAIL bias_reads got=%0d exp=%0d", ba_q.size(),
               (total > 0) ? nch : 0);
    end
    for (int k = 0; k < ba_q.size() && k < nch; k++) begin
      checks++;
      if (ba_q[k] != k) begin
        failures++;
        $display("FAIL bias_addr[%0d] got=%0d exp=%0d", k, ba_q[k], k);
      end
    end
    if (total > 0) begin
      checks++;
      if (bubble != 2 * (nch - 1)) begin
        failures++;
        $display("FAIL ready_bubble got=%0d exp=%0d",
                 bubble, 2 * (nch - 1));
      end
    end
    checks++;
    if (idle_bad != 0) begin
      failures++;
      $display("FAIL idle_outputs got=%0d exp=0", idle_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, bias_cs, bias_addr, out_cs, out_we,
         out_addr, out_wdata, finish} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=nonzero exp=0");
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, bias_cs, out_cs, finish} !== 4'b0) begin
      failures++;
      $display("FAIL idle_outputs got=%b exp=0000",
               {in_ready, bias_cs, out_cs, finish});
    end
  endtask

  task automatic test_directed();
    logic [15:0] exp_w[4];
`ifdef OUT_WRITER_RELU_EN
    exp_w = '{16'h0003, 16'h0004, 16'h0000, 16'h007F};
`else
    exp_w = '{16'h0003, 16'h0004, 16'hFFF6, 16'h007F};
`endif
    acc_q.delete();
    acc_q.push_back(32'd0);
    acc_q.push_back(32'd6);
    acc_q.push_back(32'hFFFF_FFCE);
    acc_q.push_back(32'd1000);
    bias_mem[0] = 32'd10;
    start_layer(1, 4, 2, 'h100);
    drive(4, 0, -1);
    check_layer(1, 4, 2, 'h100);
    for (int i = 0; i < 4 && i < wd_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_w[i]) begin
        failures++;
        $display("FAIL directed[%0d] got=%h exp=%h",
                 i, wd_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_channels();
    fill_random(6, 3, 2000);
    start_layer(3, 2, 3, 'h20);
    drive(6, 0, -1);
    check_layer(3, 2, 3, 'h20);
  endtask

  task automatic test_gaps();
    fill_random(10, 2, 5000);
    start_layer(2, 5, 4, 'h3000);
    drive(10, 40, -1);
    check_layer(2, 5, 4, 'h3000);
  endtask

  task automatic test_saturation();
    logic [15:0] neg_exp;
`ifdef OUT_WRITER_RELU_EN
    neg_exp = 16'h0000;
`else
    neg_exp = 16'hFF80;
`endif
    acc_q.delete();
    acc_q.push_back(32'h7FFF_FFFF);
    acc_q.push_back(32'h8000_0000);
    bias_mem[0] = 32'h7FFF_FFFF;
    bias_mem[1] = 32'h8000_0000;
    start_layer(2, 1, 0, 'h10);
    drive(2, 0, -1);
    check_layer(2, 1, 0, 'h10);
    checks++;
    if (wd_q.size() < 2 || wd_q[0] !== 16'h007F) begin
      failures++;
      $display("FAIL sat_pos got=%h exp=007F",
               (wd_q.size() > 0) ? wd_q[0] : 16'hxxxx);
    end
    checks++;
    if (wd_q.size() < 2 || wd_q[1] !== neg_exp) begin
      failures++;
      $display("FAIL sat_neg got=%h exp=%h",
               (wd_q.size() > 1) ? wd_q[1] : 16'hxxxx, neg_exp);
    end
  endtask

  task automatic test_zero();
    start_layer(0, 5, 1, 'h50);
    check_layer(0, 5, 1, 'h50);
    start_layer(3, 0, 1, 'h50);
    check_layer(3, 0, 1, 'h50);
  endtask

  task automatic test_busy_start();
    fill_random(12, 2, 3000);
    start_layer(2, 6, 2, 'h200);
    drive(12, 20, 3);
    check_layer(2, 6, 2, 'h200);
  endtask

  task automatic test_midreset();
    fill_random(40, 2, 3000);
    start_layer(2, 20, 3, 'h40);
    drive(8, 0, -1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, bias_cs, bias_addr, out_cs, out_we,
         out_addr, out_wdata, finish} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=nonzero exp=0");
    end
    repeat (2) @(negedge clk);
    clear_caps();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (wa_q.size() != 0 || fin_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset writes=%0d finish=%0d exp=0",
               wa_q.size(), fin_q.size());
    end
    fill_random(8, 2, 3000);
    start_layer(2, 4, 1, 'h77);
    drive(8, 25, -1);
    check_layer(2, 4, 1, 'h77);
  endtask

  task automatic test_random();
    int nch;
    int len;
    int sh;
    int base;
    for (int it = 0; it < 5; it++) begin
      nch = $urandom_range(1, 4);
      len = $urandom_range(1, 8);
      sh = $urandom_range(0, 31);
      base = (it == 0) ? ((1 << ADDR_W) - 3)
                       : $urandom_range(0, (1 << ADDR_W) - 1);
      fill_random(nch * len, nch, (it % 2) ? 0 : 400);
      start_layer(nch, len, sh, base);
      drive(nch * len, $urandom_range(0, 50), -1);
      check_layer(nch, len, sh, base);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_channels();
    test_gaps();
    test_saturation();
    test_zero();
    test_busy_start();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
